// File: rtl/shift_register_universal_if.sv
// Bus bundle for the universal shift register: control/data inputs and
// register outputs. The master side drives the mode and data; the slave side
// is the register.
interface shift_register_universal_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             enable;
    logic [1:0]       mode;
    logic             serial_in_msb;
    logic             serial_in_lsb;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] nQ;
    logic             serial_out_lsb;
    logic             serial_out_msb;
    logic [CW-1:0]    shift_count;
    logic             word_done;

    modport master (
        output enable, mode, serial_in_msb, serial_in_lsb, parallel_in,
        input  Q, nQ, serial_out_lsb, serial_out_msb, shift_count, word_done
    );

    modport slave (
        input  enable, mode, serial_in_msb, serial_in_lsb, parallel_in,
        output Q, nQ, serial_out_lsb, serial_out_msb, shift_count, word_done
    );
endinterface

// File: rtl/shift_register_universal.sv
// WIDTH-bit universal shift register (hold / shift right / shift left /
// parallel load) with a shift counter that pulses word_done once every WIDTH
// shifts since the last load or reset.
module shift_register_universal #(
    parameter int WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    shift_register_universal_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    count_reg;
    logic             word_done_reg;
    logic             shift_edge;
    logic             load_edge;

    // Next-state mux in front of each flip-flop, plus shift/load qualifiers
    always_comb begin
        q_next     = q_reg;
        shift_edge = 1'b0;
        load_edge  = 1'b0;
        if (bus.enable) begin
            case (bus.mode)
                MODE_SHR: begin
                    q_next     = {bus.serial_in_msb, q_reg[WIDTH-1:1]};
                    shift_edge = 1'b1;
                end
                MODE_SHL: begin
                    q_next     = {q_reg[WIDTH-2:0], bus.serial_in_lsb};
                    shift_edge = 1'b1;
                end
                MODE_LOAD: begin
                    q_next    = bus.parallel_in;
                    load_edge = 1'b1;
                end
                MODE_HOLD: begin
                    q_next = q_reg;
                end
                default: begin
                    q_next = q_reg;
                end
            endcase
        end
    end

    // Register, word counter and one-cycle word_done pulse; reset wins over all
    always_ff @(posedge clock) begin
        if (!reset) begin
            q_reg         <= '0;
            count_reg     <= '0;
            word_done_reg <= 1'b0;
        end else begin
            q_reg <= q_next;
            if (load_edge) begin
                count_reg     <= '0;
                word_done_reg <= 1'b0;
            end else if (shift_edge) begin
                if (count_reg == LAST_SHIFT) begin
                    count_reg     <= '0;
                    word_done_reg <= 1'b1;
                end else begin
                    count_reg     <= count_reg + 1'b1;
                    word_done_reg <= 1'b0;
                end
            end else begin
                word_done_reg <= 1'b0;
            end
        end
    end

    assign bus.Q              = q_reg;
    assign bus.nQ             = ~q_reg;
    assign bus.serial_out_lsb = q_reg[0];
    assign bus.serial_out_msb = q_reg[WIDTH-1];
    assign bus.shift_count    = count_reg;
    assign bus.word_done      = word_done_reg;
endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal (WIDTH=8): directed scenarios plus a
// randomized run, all checked against an arithmetic reference model.
module tb_shift_register_universal;
    localparam int W = 8;

    logic clock;
    logic reset;

    shift_register_universal_if #(.WIDTH(W)) sr ();

    shift_register_universal #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sr.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: register value as a number, shifts counted since the
    // last load/reset as a plain integer; the counter output is that modulo W.
    logic [W-1:0] m_q;
    int           m_shifts;
    bit           m_wd;

    // Drive one edge worth of inputs, advance the model, sample after the edge
    task automatic apply(input bit r, input bit en, input bit [1:0] md,
                         input bit smsb, input bit slsb, input bit [W-1:0] pin);
        reset            = r;
        sr.enable        = en;
        sr.mode          = md;
        sr.serial_in_msb = smsb;
        sr.serial_in_lsb = slsb;
        sr.parallel_in   = pin;
        if (!r) begin
            m_q = '0; m_shifts = 0; m_wd = 0;
        end else if (en && (md == 2'd1 || md == 2'd2)) begin
            if (md == 2'd1) m_q = (m_q >> 1) | (W'(smsb) << (W - 1));
            else            m_q = (m_q << 1) | W'(slsb);
            m_shifts = m_shifts + 1;
            m_wd     = (m_shifts % W) == 0;
        end else if (en && md == 2'd3) begin
            m_q = pin; m_shifts = 0; m_wd = 0;
        end else begin
            m_wd = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'hA5);
        n_total++; if (sr.Q !== 8'h00) $display("FAIL reset_q got %h want 00", sr.Q); else n_pass++;
        n_total++; if (sr.nQ !== 8'hFF) $display("FAIL reset_nq got %h want ff", sr.nQ); else n_pass++;
        n_total++; if (sr.shift_count !== 3'd0) $display("FAIL reset_count got %0d want 0", sr.shift_count); else n_pass++;
        n_total++; if (sr.word_done !== 1'b0) $display("FAIL reset_wd got %b want 0", sr.word_done); else n_pass++;
    endtask

    task automatic test_shift_right();
        apply(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'hA5);
        apply(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
        n_total++; if (sr.Q !== 8'hD2) $display("FAIL shr_q got %h want d2", sr.Q); else n_pass++;
        n_total++; if (sr.serial_out_lsb !== 1'b0) $display("FAIL shr_sol got %b want 0", sr.serial_out_lsb); else n_pass++;
        n_total++; if (sr.shift_count !== 3'd1) $display("FAIL shr_count got %0d want 1", sr.shift_count); else n_pass++;
        n_total++; if (sr.nQ !== 8'h2D) $display("FAIL shr_nq got %h want 2d", sr.nQ); else n_pass++;
    endtask

    task automatic test_shift_left();
        apply(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h81);
        apply(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
        n_total++; if (sr.Q !== 8'h02) $display("FAIL shl_q got %h want 02", sr.Q); else n_pass++;
        n_total++; if (sr.serial_out_msb !== 1'b0) $display("FAIL shl_som got %b want 0", sr.serial_out_msb); else n_pass++;
        n_total++; if (sr.shift_count !== 3'd1) $display("FAIL shl_count got %0d want 1", sr.shift_count); else n_pass++;
    endtask

    task automatic test_word();
        bit [7:0] pat;
        pat = 8'b0100_1101;  // bit i is the serial bit of edge i+1: 1,0,1,1,0,0,1,0
        apply(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b1, 2'd1, pat[i], 1'b0, 8'h00);
            n_total++;
            if (sr.word_done !== (i == 7))
                $display("FAIL word_wd edge %0d got %b want %b", i + 1, sr.word_done, i == 7);
            else n_pass++;
        end
        n_total++; if (sr.Q !== 8'h4D) $display("FAIL word_q got %h want 4d", sr.Q); else n_pass++;
        n_total++; if (sr.shift_count !== 3'd0) $display("FAIL word_count got %0d want 0", sr.shift_count); else n_pass++;
        apply(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
        n_total++; if (sr.word_done !== 1'b0) $display("FAIL word_wd_after got %b want 0", sr.word_done); else n_pass++;
    endtask

    task automatic test_hold();
        logic [W-1:0] held;
        apply(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h3C);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 8'h00);
        held = m_q;
        for (int i = 0; i < 4; i++) begin
            if (i < 2) apply(1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hFF);
            else       apply(1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 8'hFF);
            n_total++;
            if (sr.Q !== held || sr.shift_count !== 3'd3 || sr.word_done !== 1'b0)
                $display("FAIL hold_%0d got q=%h cnt=%0d wd=%b want q=%h cnt=3 wd=0",
                         i, sr.Q, sr.shift_count, sr.word_done, held);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, (i % 2) ? 2'd1 : 2'd2, 1'b0, 1'b1, 8'h00);
            n_total++;
            if (sr.word_done !== (i == 4))
                $display("FAIL hold_resume_wd shift %0d got %b want %b", i + 1, sr.word_done, i == 4);
            else n_pass++;
        end
    endtask

    task automatic test_restart();
        for (int v = 0; v < 2; v++) begin
            apply(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
            for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
            if (v == 0) apply(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
            else        apply(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h96);
            n_total++;
            if (sr.shift_count !== 3'd0)
                $display("FAIL restart%0d_count got %0d want 0", v, sr.shift_count);
            else n_pass++;
            for (int i = 0; i < 8; i++) begin
                apply(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 8'h00);
                n_total++;
                if (sr.word_done !== (i == 7))
                    $display("FAIL restart%0d_wd shift %0d got %b want %b", v, i + 1, sr.word_done, i == 7);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        apply(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 24; i++) begin
            apply(1'b1, 1'b1, (i % 3 == 0) ? 2'd2 : 2'd1, 1'(i), 1'(i >> 1), 8'h00);
            n_total++;
            if (sr.word_done !== m_wd || sr.Q !== m_q)
                $display("FAIL b2b shift %0d got wd=%b q=%h want wd=%b q=%h",
                         i + 1, sr.word_done, sr.Q, m_wd, m_q);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), W'($urandom));
            n_total++;
            if (sr.Q !== m_q || sr.nQ !== ~m_q || sr.serial_out_lsb !== m_q[0] ||
                sr.serial_out_msb !== m_q[W-1] || sr.shift_count !== 3'(m_shifts % W) ||
                sr.word_done !== m_wd)
                $display("FAIL rand cycle %0d got q=%h nq=%h cnt=%0d wd=%b want q=%h cnt=%0d wd=%b",
                         i, sr.Q, sr.nQ, sr.shift_count, sr.word_done, m_q, m_shifts % W, m_wd);
            else n_pass++;
        end
    endtask

    initial begin
        reset            = 1'b0;
        sr.enable        = 1'b0;
        sr.mode          = 2'd0;
        sr.serial_in_msb = 1'b0;
        sr.serial_in_lsb = 1'b0;
        sr.parallel_in   = '0;
        m_q = '0; m_shifts = 0; m_wd = 0;
        test_reset();
        test_shift_right();
        test_shift_left();
        test_word();
        test_hold();
        test_restart();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
